// File: rtl/tlc_fsm_if.sv
// Signal bundle between the traffic-light sequencer and its sensors/lamps.
// The slave modport is the sequencer side; the master modport is the environment side.
interface tlc_fsm_if;
  logic       car_side;
  logic       ped_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       ped_walk;
  logic [2:0] state_out;
  logic [7:0] remain;

  modport master (
    output car_side,
    output ped_req,
    input  main_light,
    input  side_light,
    input  ped_walk,
    input  state_out,
    input  remain
  );

  modport slave (
    input  car_side,
    input  ped_req,
    output main_light,
    output side_light,
    output ped_walk,
    output state_out,
    output remain
  );
endinterface

// File: rtl/tlc_fsm.sv
// Main/side-road traffic-light sequencer on the 1 Hz tick clock.
// The side road gets green only on demand; each phase lasts a fixed number of ticks.
module tlc_fsm #(
  parameter int unsigned T_MAIN_G = 10,
  parameter int unsigned T_SIDE_G = 5,
  parameter int unsigned T_YEL    = 2,
  parameter int unsigned T_ALLRED = 1
) (
  input  logic       clk,
  input  logic       reset,
  tlc_fsm_if.slave   io
);

  if (T_MAIN_G < 1 || T_MAIN_G > 255 || T_SIDE_G < 1 || T_SIDE_G > 255 ||
      T_YEL < 1 || T_YEL > 255 || T_ALLRED < 1 || T_ALLRED > 255) begin : g_param_check
    $error("tlc_fsm: phase durations must lie in 1..255");
  end

  typedef enum logic [2:0] {
    MAIN_G  = 3'd0,
    MAIN_Y  = 3'd1,
    ALLRED1 = 3'd2,
    SIDE_G  = 3'd3,
    SIDE_Y  = 3'd4,
    ALLRED2 = 3'd5
  } state_e;

  localparam logic [7:0] LD_MAIN_G = 8'(T_MAIN_G - 1);
  localparam logic [7:0] LD_SIDE_G = 8'(T_SIDE_G - 1);
  localparam logic [7:0] LD_YEL    = 8'(T_YEL - 1);
  localparam logic [7:0] LD_ALLRED = 8'(T_ALLRED - 1);

  // Raw bits rather than state_e so the unused codes 6/7 stay representable and recoverable.
  logic [2:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       ped_pend_q, ped_pend_d;
  logic       demand;
  logic       side_handoff;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MAIN_G;
      timer_q    <= LD_MAIN_G;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    demand  = io.car_side | ped_pend_q | io.ped_req;

    if (state_q > ALLRED2) begin
      state_d = MAIN_G;
      timer_d = LD_MAIN_G;
    end else if (timer_q != '0) begin
      timer_d = timer_q - 8'd1;
    end else begin
      case (state_q)
        MAIN_G: begin
          // With no demand the timer simply rests at 0 and MAIN_G persists.
          if (demand) begin
            state_d = MAIN_Y;
            timer_d = LD_YEL;
          end
        end
        MAIN_Y: begin
          state_d = ALLRED1;
          timer_d = LD_ALLRED;
        end
        ALLRED1: begin
          state_d = SIDE_G;
          timer_d = LD_SIDE_G;
        end
        SIDE_G: begin
          state_d = SIDE_Y;
          timer_d = LD_YEL;
        end
        SIDE_Y: begin
          state_d = ALLRED2;
          timer_d = LD_ALLRED;
        end
        ALLRED2: begin
          state_d = MAIN_G;
          timer_d = LD_MAIN_G;
        end
        default: begin
          state_d = MAIN_G;
          timer_d = LD_MAIN_G;
        end
      endcase
    end
  end

  // The walk about to start serves any pending request, including one raised on its entry edge.
  always_comb begin
    side_handoff = (state_q == ALLRED1) && (timer_q == '0);
    ped_pend_d   = (ped_pend_q | io.ped_req) & ~side_handoff & (state_q != SIDE_G);
  end

  always_comb begin
    io.main_light = 3'b100;
    io.side_light = 3'b100;
    io.ped_walk   = 1'b0;
    case (state_q)
      MAIN_G: io.main_light = 3'b001;
      MAIN_Y: io.main_light = 3'b010;
      SIDE_G: begin
        io.side_light = 3'b001;
        io.ped_walk   = 1'b1;
      end
      SIDE_Y: io.side_light = 3'b010;
      default: begin
        io.main_light = 3'b100;
        io.side_light = 3'b100;
      end
    endcase
    io.state_out = state_q;
    io.remain    = timer_q + 8'd1;
  end

endmodule

// File: tb/tb_tlc_fsm.sv
// Scoreboard bench for tlc_fsm: directed cycle-by-cycle expectations queued by the
// stimulus process and popped by a negedge monitor.
module tb_tlc_fsm;
  localparam int unsigned TMG = 10;
  localparam int unsigned TSG = 5;
  localparam int unsigned TY  = 2;
  localparam int unsigned TAR = 1;

  if (TMG == 0 || TSG == 0 || TY == 0 || TAR == 0) begin : g_param_check
    $error("tb_tlc_fsm: zero phase duration is illegal");
  end

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlc_fsm_if bus ();

  tlc_fsm #(
    .T_MAIN_G(TMG),
    .T_SIDE_G(TSG),
    .T_YEL   (TY),
    .T_ALLRED(TAR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  typedef struct {
    logic [2:0] st;
    logic [7:0] rem;
    logic       pp_care;
    logic       pp;
    int         tid;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   tid   = 0;

  function automatic void lamps(input logic [2:0] st, output logic [2:0] m,
                                output logic [2:0] s, output logic w);
    m = 3'b100; s = 3'b100; w = 1'b0;
    case (st)
      3'd0: m = 3'b001;
      3'd1: m = 3'b010;
      3'd3: begin s = 3'b001; w = 1'b1; end
      3'd4: s = 3'b010;
      default: ;
    endcase
  endfunction

  function automatic void chk(input string name, input int t, input int c,
                              input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s test%0d cyc%0d actual=%0h expected=%0h", name, t, c, act, expv);
    end
  endfunction

  // Monitor: every cycle the DUT presents a new light set; compare against the queue head.
  exp_t       e;
  logic [2:0] em, es;
  logic       ew;
  logic       safe;
  always @(negedge clk) begin
    safe = $onehot(bus.main_light) && $onehot(bus.side_light) &&
           (bus.main_light == 3'b100 || bus.side_light == 3'b100);
    chk("safety", tid, -1, 32'(safe), 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      lamps(e.st, em, es, ew);
      chk("state_out",  e.tid, e.cyc, 32'(bus.state_out),  32'(e.st));
      chk("main_light", e.tid, e.cyc, 32'(bus.main_light), 32'(em));
      chk("side_light", e.tid, e.cyc, 32'(bus.side_light), 32'(es));
      chk("ped_walk",   e.tid, e.cyc, 32'(bus.ped_walk),   32'(ew));
      chk("remain",     e.tid, e.cyc, 32'(bus.remain),     32'(e.rem));
      if (e.pp_care) chk("ped_pend", e.tid, e.cyc, 32'(dut.ped_pend_q), 32'(e.pp));
    end
  end

  task automatic step(input logic car, input logic ped, input logic rst,
                      input logic [2:0] st, input logic [7:0] rem,
                      input logic pp, input int c);
    bus.car_side = car;
    bus.ped_req  = ped;
    reset        = rst;
    q.push_back('{st, rem, 1'b1, pp, tid, c});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.car_side = 1'b0;
    bus.ped_req  = 1'b0;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Hand-derived side sequence starting at the first MAIN_Y cycle (offset 0).
  function automatic void side_exp(input int off, output logic [2:0] st, output logic [7:0] rem);
    if (off < 2)       begin st = 3'd1; rem = 8'(2 - off);  end
    else if (off == 2) begin st = 3'd2; rem = 8'd1;         end
    else if (off < 8)  begin st = 3'd3; rem = 8'(8 - off);  end
    else if (off < 10) begin st = 3'd4; rem = 8'(10 - off); end
    else               begin st = 3'd5; rem = 8'd1;         end
  endfunction

  function automatic logic [7:0] main_rem(input int k);
    return (k < 10) ? 8'(10 - k) : 8'd1;
  endfunction

  // car high for cycles <= car_last; ped pulse at ped_at; side sequence begins at y;
  // reset pulse at rst_at; ped_pend expected high for pp_set <= c < pp_clr.
  task automatic run(input int ncyc, input int car_last, input int ped_at, input int y,
                     input int rst_at, input int pp_set, input int pp_clr);
    logic [2:0] st;
    logic [7:0] rem;
    for (int c = 0; c < ncyc; c++) begin
      if (rst_at >= 0 && c > rst_at) begin
        st = 3'd0; rem = main_rem(c - rst_at - 1);
      end else if (y < 0 || c < y) begin
        st = 3'd0; rem = main_rem(c);
      end else if (c < y + 11) begin
        side_exp(c - y, st, rem);
      end else begin
        st = 3'd0; rem = main_rem(c - y - 11);
      end
      step(c <= car_last, c == ped_at, c == rst_at, st, rem,
           (c >= pp_set && c < pp_clr), c);
    end
  endtask

  initial begin
    tid = 1; do_reset(); run(40, -1, -1, -1, -1, 99, 99);   // no demand: MAIN_G forever
    tid = 2; do_reset(); run(23, 99, -1, 10, -1, 99, 99);   // continuous car
    tid = 3; do_reset(); run(45, -1, 3, 10, -1, 4, 13);     // ped pulse at 3
    tid = 4; do_reset(); run(41, 9, 15, 10, -1, 99, 99);    // ped during SIDE_G ignored
    tid = 5; do_reset(); run(41, 9, 12, 10, -1, 99, 99);    // ped on ALLRED1 last cycle
    tid = 6; do_reset(); run(20, 9, -1, 10, 15, 99, 99);    // reset inside SIDE_G
    tid = 7; do_reset(); run(12, -1, 3, -1, 8, 4, 9);       // reset clears pending ped

    tid = 8; do_reset();
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'd10, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'd9,  1'b0, 1);
    force dut.state_q = 3'd7;
    q.push_back('{3'd7, 8'd8, 1'b1, 1'b0, tid, 2});
    @(negedge clk);
    #1;
    release dut.state_q;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'd10, 1'b0, 3);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'd9,  1'b0, 4);

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", tid, -1, 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
